apb_master_n: RTL and testbench

APB_MASTER_N -- requirements
Module: apb_master_n

---
 rtl/apb_master_n.sv | 210 +++++++++++++++++++++
 tb/tb_apb_master_n.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/apb_master_n.sv
// apb_master_n: command-to-APB bridge driving NSLV completers.
//
// A command (cmd_valid/cmd_ready handshake) is decoded to a completer index
// taken from cmd_addr[SLV_AW+IW-1:SLV_AW]. Valid indices run a standard
// SETUP/ACCESS transfer on the APB bus; out-of-range indices are rejected
// without touching the bus. Every accepted command yields exactly one
// single-cycle response (rsp_valid/rsp_rdata/rsp_err). A completer that
// holds PREADY low for TIMEOUT ACCESS edges is aborted with an error.
//
// Ports:
//   PCLK, PRESETn            clock (rising edge), async active-low reset
//   cmd_valid/cmd_ready      command handshake
//   cmd_write/addr/wdata     command payload
//   rsp_valid/rdata/err      one-cycle response, no back-pressure
//   PSEL[NSLV], PENABLE,     APB requester outputs (all registered)
//   PWRITE, PADDR, PWDATA
//   PRDATA[NSLV*DATA_W],     APB completer inputs; slice/bit i belongs
//   PREADY[NSLV],            to completer i
//   PSLVERR[NSLV]
//
// state  | meaning
// IDLE   | ready for a command; bus idle, address/data hold last values
// SETUP  | one cycle with PSEL set, PENABLE low
// ACCESS | PENABLE high, waiting on PREADY of the selected completer

module apb_master_n #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int NSLV    = 4,
    parameter int SLV_AW  = 8,
    parameter int TIMEOUT = 16
) (
    input  logic                     PCLK,
    input  logic                     PRESETn,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic                     cmd_write,
    input  logic [ADDR_W-1:0]        cmd_addr,
    input  logic [DATA_W-1:0]        cmd_wdata,
    output logic                     rsp_valid,
    output logic [DATA_W-1:0]        rsp_rdata,
    output logic                     rsp_err,
    output logic [NSLV-1:0]          PSEL,
    output logic                     PENABLE,
    output logic                     PWRITE,
    output logic [ADDR_W-1:0]        PADDR,
    output logic [DATA_W-1:0]        PWDATA,
    input  logic [NSLV*DATA_W-1:0]   PRDATA,
    input  logic [NSLV-1:0]          PREADY,
    input  logic [NSLV-1:0]          PSLVERR
);

    localparam int IW = (NSLV > 1) ? $clog2(NSLV) : 1;
    localparam logic [7:0] TO_CNT = 8'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    state_t              state_q, state_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [7:0]          wait_q, wait_d;
    logic                derr_q, derr_d;
    logic                cmd_ready_q, cmd_ready_d;
    logic [NSLV-1:0]     psel_q, psel_d;
    logic                penable_q, penable_d;
    logic                pwrite_q, pwrite_d;
    logic [ADDR_W-1:0]   paddr_q, paddr_d;
    logic [DATA_W-1:0]   pwdata_q, pwdata_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                rsp_err_q, rsp_err_d;

    logic [IW-1:0]       cmd_idx;
    logic                accept;
    logic                sel_ready;
    logic                sel_err;
    logic [DATA_W-1:0]   sel_rdata;

    always_comb begin
        cmd_idx = cmd_addr[SLV_AW+IW-1:SLV_AW];
        accept  = cmd_valid && cmd_ready_q;

        // Only the addressed completer's response signals are looked at.
        sel_ready = 1'b0;
        sel_err   = 1'b0;
        sel_rdata = '0;
        for (int i = 0; i < NSLV; i++) begin
            if (idx_q == IW'(i)) begin
                sel_ready = PREADY[i];
                sel_err   = PSLVERR[i];
                sel_rdata = PRDATA[i*DATA_W +: DATA_W];
            end
        end

        state_d     = state_q;
        idx_d       = idx_q;
        wait_d      = wait_q;
        derr_d      = 1'b0;
        psel_d      = psel_q;
        penable_d   = penable_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = '0;
        rsp_err_d   = 1'b0;

        // A rejected command answers one edge after its accept; the FSM
        // stays in IDLE meanwhile, so this never collides with a bus response.
        if (derr_q) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (int'(cmd_idx) < NSLV) begin
                        state_d   = SETUP;
                        idx_d     = cmd_idx;
                        penable_d = 1'b0;
                        pwrite_d  = cmd_write;
                        paddr_d   = cmd_addr;
                        pwdata_d  = cmd_wdata;
                        for (int i = 0; i < NSLV; i++) begin
                            psel_d[i] = (cmd_idx == IW'(i));
                        end
                    end else begin
                        derr_d = 1'b1;
                    end
                end
            end
            SETUP: begin
                state_d   = ACCESS;
                penable_d = 1'b1;
                wait_d    = '0;
            end
            ACCESS: begin
                // Completion is tested first so a PREADY arriving on the
                // timeout edge still finishes normally.
                if (sel_ready) begin
                    state_d     = IDLE;
                    psel_d      = '0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = sel_err;
                    rsp_rdata_d = pwrite_q ? '0 : sel_rdata;
                end else begin
                    wait_d = wait_q + 8'd1;
                    if (wait_d == TO_CNT) begin
                        state_d     = IDLE;
                        psel_d      = '0;
                        penable_d   = 1'b0;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                    end
                end
            end
            default: begin
                state_d   = IDLE;
                psel_d    = '0;
                penable_d = 1'b0;
            end
        endcase

        cmd_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            wait_q      <= '0;
            derr_q      <= 1'b0;
            cmd_ready_q <= 1'b0;
            psel_q      <= '0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            wait_q      <= wait_d;
            derr_q      <= derr_d;
            cmd_ready_q <= cmd_ready_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign PSEL      = psel_q;
    assign PENABLE   = penable_q;
    assign PWRITE    = pwrite_q;
    assign PADDR     = paddr_q;
    assign PWDATA    = pwdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_apb_master_n.sv
// Bench for apb_master_n: a 4-completer instance (TIMEOUT=16) exercised with
// directed and randomized transfers, plus a 3-completer instance for the
// out-of-range decode. Expected behaviour per transfer is derived from the
// planned wait count: response latency, abort, error and read data.

module tb_apb_master_n;

    localparam int NS = 4;
    localparam int TO = 16;

    logic PCLK = 1'b0;
    logic PRESETn;
    always #5 PCLK = ~PCLK;

    logic              cmd_valid, cmd_ready, cmd_write;
    logic [31:0]       cmd_addr, cmd_wdata;
    logic              rsp_valid, rsp_err;
    logic [31:0]       rsp_rdata;
    logic [NS-1:0]     PSEL;
    logic              PENABLE, PWRITE;
    logic [31:0]       PADDR, PWDATA;
    logic [NS*32-1:0]  PRDATA;
    logic [NS-1:0]     PREADY, PSLVERR;

    logic              c3_valid, c3_ready, c3_write;
    logic [31:0]       c3_addr, c3_wdata;
    logic              r3_valid, r3_err;
    logic [31:0]       r3_rdata;
    logic [2:0]        p3_sel;
    logic              p3_enable, p3_write;
    logic [31:0]       p3_addr, p3_wdata;
    logic [3*32-1:0]   p3_rdata;
    logic [2:0]        p3_ready, p3_slverr;

    apb_master_n #(.ADDR_W(32), .DATA_W(32), .NSLV(NS), .SLV_AW(8), .TIMEOUT(TO)) u_dut (
        .PCLK(PCLK), .PRESETn(PRESETn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
        .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    apb_master_n #(.ADDR_W(32), .DATA_W(32), .NSLV(3), .SLV_AW(8), .TIMEOUT(TO)) u_dut3 (
        .PCLK(PCLK), .PRESETn(PRESETn),
        .cmd_valid(c3_valid), .cmd_ready(c3_ready), .cmd_write(c3_write),
        .cmd_addr(c3_addr), .cmd_wdata(c3_wdata),
        .rsp_valid(r3_valid), .rsp_rdata(r3_rdata), .rsp_err(r3_err),
        .PSEL(p3_sel), .PENABLE(p3_enable), .PWRITE(p3_write), .PADDR(p3_addr), .PWDATA(p3_wdata),
        .PRDATA(p3_rdata), .PREADY(p3_ready), .PSLVERR(p3_slverr)
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One transfer on u_dut. The target completer holds PREADY low for
    // 'waits' ACCESS edges; others drive random noise throughout.
    task automatic run_txn(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                           input int waits, input bit serr, input logic [31:0] rdata);
        int tgt;
        int lat;
        bit abort;
        logic [NS-1:0] onehot;
        tgt    = int'(addr[9:8]);
        abort  = (waits >= TO);
        lat    = abort ? TO + 1 : 2 + waits;
        onehot = '0;
        onehot[tgt] = 1'b1;
        for (int i = 0; i < NS; i++) PRDATA[i*32 +: 32] = (i == tgt) ? rdata : $urandom;
        PSLVERR = NS'($urandom);
        PSLVERR[tgt] = serr;
        PREADY = NS'($urandom);
        PREADY[tgt] = 1'b0;
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_wdata = wdata;
        check("cmd_ready_at_accept", cmd_ready, 1);
        @(posedge PCLK); #1;
        cmd_valid = 1'b0;
        cmd_write = 1'($urandom);
        cmd_addr  = $urandom;
        cmd_wdata = $urandom;
        for (int n = 0; n <= lat; n++) begin
            if (n > 0) begin
                PREADY = NS'($urandom);
                PREADY[tgt] = (n == 2 + waits);
                PSLVERR = NS'($urandom);
                PSLVERR[tgt] = serr;
                @(posedge PCLK); #1;
            end
            check("psel", PSEL, (n < lat) ? onehot : '0);
            check("penable", PENABLE, (n >= 1 && n < lat));
            check("rsp_valid", rsp_valid, (n == lat));
            check("cmd_ready", cmd_ready, (n == lat));
            check("paddr_hold", PADDR, addr);
            if (n < lat) begin
                check("pwrite", PWRITE, wr);
                check("pwdata", PWDATA, wdata);
            end else begin
                check("rsp_err", rsp_err, abort || serr);
                check("rsp_rdata", rsp_rdata, (abort || wr) ? 32'h0 : rdata);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        PRESETn   = 1'b0;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        PRDATA = '0; PREADY = '0; PSLVERR = '0;
        c3_valid = 1'b0; c3_write = 1'b0; c3_addr = '0; c3_wdata = '0;
        p3_rdata = '0; p3_ready = '0; p3_slverr = '0;

        // reset values
        #3;
        check("rst_cmd_ready", cmd_ready, 0);
        check("rst_psel", PSEL, 0);
        check("rst_penable", PENABLE, 0);
        check("rst_paddr", PADDR, 0);
        check("rst_pwdata", PWDATA, 0);
        check("rst_rsp", {rsp_valid, rsp_err, rsp_rdata}, 0);
        #19;
        PRESETn = 1'b1;
        #1;
        check("cmd_ready_before_edge", cmd_ready, 0);
        @(posedge PCLK); #1;
        check("cmd_ready_after_release", cmd_ready, 1);
        check("cmd3_ready_after_release", c3_ready, 1);

        // zero-wait write to completer 2
        run_txn(1'b1, 32'h0000_0210, 32'hA5A5_0001, 0, 1'b0, 32'h1111_2222);
        // read with 3 wait states from completer 1 (issued back-to-back)
        run_txn(1'b0, 32'h0000_0104, 32'h0, 3, 1'b0, 32'hDEAD_BEEF);
        // slave error on completer 3, then a back-to-back command
        run_txn(1'b1, 32'h0000_0300, 32'h0BAD_0003, 0, 1'b1, 32'h0);
        run_txn(1'b0, 32'h0000_0008, 32'h0, 1, 1'b0, 32'h0C0F_FEE0);
        // timeout on completer 0 and ready exactly on the timeout edge
        run_txn(1'b0, 32'h0000_0020, 32'h0, TO, 1'b0, 32'h5555_AAAA);
        run_txn(1'b0, 32'h0000_0024, 32'h0, TO - 1, 1'b0, 32'h5555_AAAA);

        // randomized transfers
        for (int k = 0; k < 30; k++) begin
            int w;
            w = ($urandom_range(0, 9) < 8) ? int'($urandom_range(0, 4)) : int'($urandom_range(14, 17));
            run_txn(1'($urandom), $urandom, $urandom, w, 1'($urandom), $urandom);
        end

        // reset in the middle of an ACCESS phase
        PREADY = '0;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h0000_0200; cmd_wdata = 32'h0;
        @(posedge PCLK); #1;
        cmd_valid = 1'b0;
        @(posedge PCLK); #1;
        check("mid_access_penable", PENABLE, 1);
        #2;
        PRESETn = 1'b0;
        #1;
        check("mid_rst_psel", PSEL, 0);
        check("mid_rst_penable", PENABLE, 0);
        check("mid_rst_paddr", PADDR, 0);
        check("mid_rst_cmd_ready", cmd_ready, 0);
        check("mid_rst_rsp", {rsp_valid, rsp_err, rsp_rdata}, 0);
        @(posedge PCLK); @(posedge PCLK); #3;
        PRESETn = 1'b1;
        PREADY = '1;
        for (int n = 0; n < 4; n++) begin
            @(posedge PCLK); #1;
            check("post_rst_no_rsp", rsp_valid, 0);
            check("post_rst_psel", PSEL, 0);
            check("post_rst_cmd_ready", cmd_ready, 1);
        end
        run_txn(1'b0, 32'h0000_0204, 32'h0, 0, 1'b0, 32'hFACE_0001);

        // decode error on the 3-completer instance
        c3_valid = 1'b1; c3_write = 1'b0; c3_addr = 32'h0000_0300;
        p3_ready = 3'b111;
        check("d3_ready", c3_ready, 1);
        @(posedge PCLK); #1;
        c3_valid = 1'b0;
        check("d3_n0_rsp", r3_valid, 0);
        check("d3_n0_psel", p3_sel, 0);
        @(posedge PCLK); #1;
        check("d3_n1_rsp", {r3_valid, r3_err, r3_rdata}, {1'b1, 1'b1, 32'h0});
        check("d3_n1_psel", p3_sel, 0);
        check("d3_n1_penable", p3_enable, 0);
        @(posedge PCLK); #1;
        check("d3_n2_rsp", r3_valid, 0);
        // highest legal index on the same instance still transfers
        p3_rdata[2*32 +: 32] = 32'h1234_5678;
        p3_ready = 3'b100;
        c3_valid = 1'b1; c3_addr = 32'h0000_0200;
        @(posedge PCLK); #1;
        c3_valid = 1'b0;
        check("d3_ok_psel", p3_sel, 3'b100);
        @(posedge PCLK); #1;
        check("d3_ok_penable", p3_enable, 1);
        @(posedge PCLK); #1;
        check("d3_ok_rsp", {r3_valid, r3_err, r3_rdata}, {1'b1, 1'b0, 32'h1234_5678});

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
